// File: rtl/math_compare_pipelined.sv
// rtl/math_compare_pipelined.sv - pipelined MSB-first magnitude comparator, one chunk per stage (signed mode: MATH_COMPARE_SIGNED_EN)
module math_compare_pipelined #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  output logic             out_valid,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int ALU_WIDTH       = (WIDTH + LATENCY - 1) / LATENCY;
  localparam int CHUNK_COUNT     = (WIDTH + ALU_WIDTH - 1) / ALU_WIDTH;
  localparam int LAST_CHUNK_SIZE = ((WIDTH % ALU_WIDTH) == 0) ? ALU_WIDTH : (WIDTH % ALU_WIDTH);

  logic [WIDTH-1:0] a_s0;
  logic [WIDTH-1:0] b_s0;

`ifdef MATH_COMPARE_SIGNED_EN
  // Flipping the sign bit maps two's complement ordering onto unsigned ordering.
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
  assign a_s0 = I1 ^ SIGN_MASK;
  assign b_s0 = I2 ^ SIGN_MASK;
`else
  assign a_s0 = I1;
  assign b_s0 = I2;
`endif

  for (genvar k = 0; k < CHUNK_COUNT; k++) begin : g_stage
    // Operand bits reaching this stage, the chunk it examines, and what it keeps for later stages.
    localparam int IN_W  = (k == 0) ? WIDTH : (CHUNK_COUNT - k) * ALU_WIDTH;
    localparam int CMP_W = (k == 0) ? LAST_CHUNK_SIZE : ALU_WIDTH;
    localparam int REM_W = IN_W - CMP_W;

    logic [IN_W-1:0]  a_in;
    logic [IN_W-1:0]  b_in;
    logic [CMP_W-1:0] a_chunk;
    logic [CMP_W-1:0] b_chunk;
    logic             prev_valid;
    logic             prev_decided;
    logic             prev_lt;
    logic             prev_gt;
    logic             valid_d, decided_d, lt_d, gt_d;
    logic             valid_q, decided_q, lt_q, gt_q;

    if (k == 0) begin : g_src
      assign a_in         = a_s0;
      assign b_in         = b_s0;
      assign prev_valid   = in_valid;
      assign prev_decided = 1'b0;
      assign prev_lt      = 1'b0;
      assign prev_gt      = 1'b0;
    end else begin : g_src
      assign a_in         = g_stage[k-1].g_rem.a_q;
      assign b_in         = g_stage[k-1].g_rem.b_q;
      assign prev_valid   = g_stage[k-1].valid_q;
      assign prev_decided = g_stage[k-1].decided_q;
      assign prev_lt      = g_stage[k-1].lt_q;
      assign prev_gt      = g_stage[k-1].gt_q;
    end

    assign a_chunk = a_in[IN_W-1 -: CMP_W];
    assign b_chunk = b_in[IN_W-1 -: CMP_W];

    // An entry already decided by a higher chunk passes through; otherwise this chunk decides it.
    always_comb begin
      valid_d   = prev_valid;
      decided_d = prev_decided;
      lt_d      = prev_lt;
      gt_d      = prev_gt;
      if (!prev_decided) begin
        decided_d = (a_chunk != b_chunk);
        lt_d      = (a_chunk < b_chunk);
        gt_d      = (a_chunk > b_chunk);
      end
    end

    // Stage control/result flags; reset clears them so nothing in flight survives.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q   <= 1'b0;
        decided_q <= 1'b0;
        lt_q      <= 1'b0;
        gt_q      <= 1'b0;
      end else if (ce) begin
        valid_q   <= valid_d;
        decided_q <= decided_d;
        lt_q      <= lt_d;
        gt_q      <= gt_d;
      end
    end

    if (REM_W > 0) begin : g_rem
      logic [REM_W-1:0] a_q;
      logic [REM_W-1:0] b_q;

      // Lower operand bits still to be examined; data needs no reset since valid qualifies it.
      always_ff @(posedge clk) begin
        if (ce) begin
          a_q <= a_in[REM_W-1:0];
          b_q <= b_in[REM_W-1:0];
        end
      end
    end
  end

  assign out_valid = g_stage[CHUNK_COUNT-1].valid_q;
  assign eq        = out_valid & ~g_stage[CHUNK_COUNT-1].decided_q;
  assign lt        = out_valid &  g_stage[CHUNK_COUNT-1].lt_q;
  assign gt        = out_valid &  g_stage[CHUNK_COUNT-1].gt_q;

endmodule

// File: tb/tb_math_compare_pipelined.sv
// tb/tb_math_compare_pipelined.sv - self-checking bench for math_compare_pipelined (8/4 and 5/4 instances)
module tb_math_compare_pipelined;

  localparam int CC8 = 4;
  localparam int CC5 = 3;
  localparam int NV  = 9;
  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_LT = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ce       = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] i1       = 8'h00;
  logic [7:0] i2       = 8'h00;
  logic       ov8, eq8, lt8, gt8;
  logic       ov5, eq5, lt5, gt5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [2:0] r;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] e8u;
    logic [2:0] e8s;
    logic [2:0] e5u;
    logic [2:0] e5s;
  } vec_t;

  exp_t q8[$];
  exp_t q5[$];
  vec_t tbl[NV];

  math_compare_pipelined #(.WIDTH(8), .LATENCY(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .I1(i1), .I2(i2),
    .out_valid(ov8), .eq(eq8), .lt(lt8), .gt(gt8)
  );

  math_compare_pipelined #(.WIDTH(5), .LATENCY(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .I1(i1[4:0]), .I2(i2[4:0]),
    .out_valid(ov5), .eq(eq5), .lt(lt5), .gt(gt5)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] cmp_ref(input logic [7:0] a, input logic [7:0] b, input int w);
    longint sa, sb;
    sa = longint'(a) & ((longint'(1) << w) - 1);
    sb = longint'(b) & ((longint'(1) << w) - 1);
`ifdef MATH_COMPARE_SIGNED_EN
    if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
    if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
`endif
    if (sa < sb) return R_LT;
    if (sa > sb) return R_GT;
    return R_EQ;
  endfunction

  function automatic logic [2:0] pick(input logic [2:0] u, input logic [2:0] s);
`ifdef MATH_COMPARE_SIGNED_EN
    return s;
`else
    return u;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    exp_t       e;
    logic [3:0] x8, x5;
    @(posedge clk);
    if (!rst_n) begin
      q8.delete();
      q5.delete();
    end else if (ce) begin
      e.v = in_valid;
      e.r = cmp_ref(i1, i2, 8);
      q8.push_back(e);
      if (q8.size() > CC8) q8.delete(0);
      e.r = cmp_ref(i1, i2, 5);
      q5.push_back(e);
      if (q5.size() > CC5) q5.delete(0);
    end
    #1;
    x8 = 4'b0;
    x5 = 4'b0;
    if (q8.size() == CC8) begin
      if (q8[0].v) x8 = {1'b1, q8[0].r};
    end
    if (q5.size() == CC5) begin
      if (q5[0].v) x5 = {1'b1, q5[0].r};
    end
    check("model_w8", {28'd0, ov8, eq8, lt8, gt8}, {28'd0, x8});
    check("model_w5", {28'd0, ov5, eq5, lt5, gt5}, {28'd0, x5});
  endtask

  initial begin
    int found;
    int seen;

    tbl[0] = '{8'h10, 8'h01, R_GT, R_GT, R_GT, R_LT};
    tbl[1] = '{8'h01, 8'h10, R_LT, R_LT, R_LT, R_GT};
    tbl[2] = '{8'hFE, 8'hFF, R_LT, R_LT, R_LT, R_LT};
    tbl[3] = '{8'h33, 8'h33, R_EQ, R_EQ, R_EQ, R_EQ};
    tbl[4] = '{8'h80, 8'h7F, R_GT, R_LT, R_LT, R_GT};
    tbl[5] = '{8'hA5, 8'hA5, R_EQ, R_EQ, R_EQ, R_EQ};
    tbl[6] = '{8'h00, 8'hFF, R_LT, R_GT, R_LT, R_GT};
    tbl[7] = '{8'h7F, 8'h80, R_LT, R_GT, R_GT, R_LT};
    tbl[8] = '{8'h10, 8'h0F, R_GT, R_GT, R_GT, R_LT};

    // Reset held for two cycles, then released with an idle pipeline.
    rst_n = 1'b0;
    repeat (2) begin
      step();
      check("reset_outputs", {28'd0, ov8, eq8, lt8, gt8}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) step();

    // Single equal pair: visible after edge 3 only, then gone.
    i1 = 8'hA5; i2 = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check("single_eq", {28'd0, ov8, eq8, lt8, gt8}, 32'b1100);
    step();
    check("single_eq_gone", {31'd0, ov8}, 32'd0);
    repeat (3) step();

    // Back-to-back vector table, results must stream out with no bubbles.
    for (int i = 0; i < NV + CC8 - 1; i++) begin
      in_valid = (i < NV);
      if (i < NV) begin
        i1 = tbl[i].a;
        i2 = tbl[i].b;
      end
      step();
      if (i >= CC8 - 1)
        check($sformatf("tbl_w8[%0d]", i - CC8 + 1), {28'd0, ov8, eq8, lt8, gt8},
              {28'd0, 1'b1, pick(tbl[i - CC8 + 1].e8u, tbl[i - CC8 + 1].e8s)});
      if (i >= CC5 - 1 && (i - CC5 + 1) < NV)
        check($sformatf("tbl_w5[%0d]", i - CC5 + 1), {28'd0, ov5, eq5, lt5, gt5},
              {28'd0, 1'b1, pick(tbl[i - CC5 + 1].e5u, tbl[i - CC5 + 1].e5s)});
    end
    in_valid = 1'b0;
    repeat (2) step();

    // ce low for three cycles mid-flight delays the result by exactly three cycles.
    i1 = 8'hC0; i2 = 8'h3F; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    found = -1;
    for (int j = 1; j <= 20 && found < 0; j++) begin
      ce = !(j >= 2 && j <= 4);
      step();
      if (ov8) found = j;
    end
    ce = 1'b1;
    check("stall_latency", found, 6);
    check("stall_result", {28'd0, ov8, eq8, lt8, gt8}, 32'b1001);
    ce = 1'b0;
    repeat (2) begin
      step();
      check("stall_hold", {28'd0, ov8, eq8, lt8, gt8}, 32'b1001);
    end
    ce = 1'b1;
    repeat (4) step();

    // Reset while a pair is in flight: it must never emerge.
    i1 = 8'h01; i2 = 8'h02; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      step();
      if (ov8 || ov5) seen++;
    end
    check("reset_flush", seen, 0);

    // Randomised traffic with stalls, bubbles and occasional resets.
    for (int n = 0; n < 400; n++) begin
      ce       = ($urandom_range(0, 7) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      rst_n    = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) begin
        i1 = 8'($urandom);
        i2 = i1 ^ (8'h01 << $urandom_range(0, 7));
      end else begin
        i1 = 8'($urandom);
        i2 = ($urandom_range(0, 4) == 0) ? i1 : 8'($urandom);
      end
      step();
    end
    rst_n = 1'b1;
    ce = 1'b1;
    in_valid = 1'b0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/math_compare_pipelined.md
Name: math_compare_pipelined

Overview:
- Pipelined magnitude comparator for the math toolbox, companion to the chunked carry-chain adder/subtractor.
- The adder ripples carry LSB->MSB one chunk per tick. This block resolves the comparison in the other direction, MSB->LSB, one chunk per tick.
- Configurable width and latency; fully pipelined, so one new operand pair is accepted per enabled clock.
- Feeds counters, limit checks and timer compare logic that cannot meet timing with a flat WIDTH-bit compare.

Parameters:
- WIDTH, 8, operand width in bits (>=1).
- LATENCY, 4, target pipeline depth in ticks (>=1).
- Derived: ALU_WIDTH = ceil(WIDTH/LATENCY).
- Derived: CHUNK_COUNT = ceil(WIDTH/ALU_WIDTH).
- Derived: LAST_CHUNK_SIZE = WIDTH%ALU_WIDTH, or ALU_WIDTH if that is 0. The last chunk is the MSB chunk.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous reset, active-low
- ce  input  1  clock enable; low freezes the entire pipeline
- in_valid  input  1  I1/I2 carry a new operand pair this cycle
- I1  input  WIDTH  operand A
- I2  input  WIDTH  operand B
- out_valid  output  1  eq/lt/gt are valid this cycle
- eq  output  1  A == B
- lt  output  1  A < B
- gt  output  1  A > B

Behaviour:
- Reset, when rst_n is low at a rising edge:
  - All stage valid bits, decided flags and result flags clear.
  - out_valid=0, eq=0, lt=0, gt=0.
  - Reset overrides ce and discards any in-flight operations; nothing in flight emerges after reset.
- Pipeline: CHUNK_COUNT register stages, S0..S(CHUNK_COUNT-1). Each stage holds:
  - valid;
  - decided;
  - res_lt and res_gt;
  - the not-yet-examined lower operand bits of A and B (bits already examined are dropped).
- Stage S0 compares chunk index CHUNK_COUNT-1 (the MSB chunk, LAST_CHUNK_SIZE bits wide) of I1 and I2 at the sampling edge.
  - decided = chunks differ.
  - res_lt/res_gt set from the chunk compare.
- Stage Sk (k>=1):
  - If the incoming entry is decided, pass it through unchanged.
  - Otherwise compare chunk CHUNK_COUNT-1-k and set decided/res accordingly.
- Output side:
  - out_valid = last stage valid.
  - lt = res_lt, gt = res_gt, eq = ~decided. Each is gated by out_valid, so all three are 0 when out_valid=0.
- Latency: a pair sampled with in_valid=1 and ce=1 at edge N appears with out_valid=1 after edge N+CHUNK_COUNT-1, counting only ce-high edges.
  - Equals LATENCY when WIDTH%LATENCY==0; otherwise <= LATENCY.
  - LATENCY >= WIDTH gives ALU_WIDTH=1 and CHUNK_COUNT=WIDTH.
  - LATENCY=1 gives a single-stage registered compare.
- Throughput: one pair per ce-high cycle; back-to-back in_valid is fully supported with no bubbles.
- in_valid=0 with ce=1 inserts a bubble (valid=0). Bubble data is don't-care, but outputs stay 0.
- ce=0: every register, including outputs, holds its value; in_valid and operands are ignored that cycle.
- Invariants:
  - Exactly one of eq/lt/gt is 1 whenever out_valid=1.
  - decided never clears once set within an entry.
- Unsigned compare by default.

Optional Feature:
- Macro: MATH_COMPARE_SIGNED_EN.
- Defined: operands are two's complement. Stage S0 inverts bit WIDTH-1 of both I1 and I2 before the MSB-chunk compare; all other chunks are unchanged. Example: 8'h80 < 8'h7F gives lt=1.
- Undefined: unsigned compare. 8'h80 vs 8'h7F gives gt=1.
- No port or latency change either way.

Test Plan:
- WIDTH=8, LATENCY=4 (4 stages of 2 bits), rst_n=0 for 2 cycles, then release -> out_valid=eq=lt=gt=0 during and after reset until the first result.
- I1=8'hA5, I2=8'hA5, in_valid one cycle at edge 0 -> after edge 3: out_valid=1, eq=1, lt=0, gt=0; next cycle out_valid=0.
- Back-to-back pairs (8'h10,8'h01), (8'h01,8'h10), (8'hFE,8'hFF), (8'h33,8'h33) -> four consecutive out_valid cycles with gt, lt, lt, eq in order.
- Pair (8'hC0,8'h3F) launched, ce=0 for 3 cycles mid-flight -> result gt=1 delayed by exactly 3 cycles; outputs held steady while ce=0.
- rst_n pulsed low 2 cycles after launching (8'h01,8'h02) -> no out_valid ever produced for that pair.
- WIDTH=5, LATENCY=4 (chunks 2,2,1), I1=5'h10, I2=5'h0F -> gt=1 after 3 edges. With MATH_COMPARE_SIGNED_EN defined, same stimulus -> lt=1.
